rf_mp_scoreboard: RTL and testbench

Parametrised multi-port integer register file for the superscalar core, replacing the fixed 4-read/2-write file. It takes NWR writeback ports, resolves same-register write conflicts by instruction age, and bypasses same-cycle writes to NRD read ports. It also keeps a per-register busy scoreboard that issue logic sets at dispatch and writeback clears. It sits between decode/issue (read, alloc) and the branch/memory/ALU writeback stages.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_write_arbiter.sv | 48 ++++
 rtl/rf_mp_scoreboard.sv | 110 +++++++++++
 tb/tb_rf_mp_scoreboard.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and age helpers for the multi-port register file.
// Ages are wrap-around sequence numbers compared by signed distance.
package rf_pkg;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;
   localparam int RF_AGE_W = 8;

   typedef logic [$clog2(RF_NREGS)-1:0] reg_addr_t;
   typedef logic [RF_AGE_W-1:0]         age_t;
   typedef logic [RF_XLEN-1:0]          xlen_t;

   function automatic logic age_newer(age_t a, age_t b);
      age_t d;
      d = a - b;
      return (d != '0) && !d[RF_AGE_W-1];
   endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// Picks the newest of the write ports hitting one register.
// Ties on age are flagged and resolved to the lowest port index.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NWR   = 2,
   parameter int AGE_W = RF_AGE_W
) (
   input  logic [NWR-1:0]            match,
   input  logic [NWR-1:0][AGE_W-1:0] age,
   output logic                      hit,
   output logic [NWR-1:0]            sel,
   output logic                      dup
);

   function automatic logic newer(
      logic [AGE_W-1:0] a,
      logic [AGE_W-1:0] b
   );
      logic [AGE_W-1:0] d;
      d = a - b;
      return (d != '0) && !d[AGE_W-1];
   endfunction

   always_comb begin
      int   best;
      logic found;
      hit   = |match;
      sel   = '0;
      dup   = 1'b0;
      best  = 0;
      found = 1'b0;
      for (int j = 0; j < NWR; j++) begin
         if (match[j]) begin
            // strict newer keeps the lower index on a tie
            if (!found || newer(age[j], age[best]))
               best = j;
            found = 1'b1;
            for (int k = 0; k < j; k++)
               if (match[k] && age[k] == age[j])
                  dup = 1'b1;
         end
      end
      if (found)
         sel[best] = 1'b1;
   end

endmodule

// File: rtl/rf_mp_scoreboard.sv
// Multi-port integer register file with age-resolved writeback,
// same-cycle read bypass and a per-register busy scoreboard.
module rf_mp_scoreboard
   import rf_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int NREGS = RF_NREGS,
   parameter int NRD   = 4,
   parameter int NWR   = 2,
   parameter int AGE_W = RF_AGE_W,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NRD-1:0][AW-1:0]    rd_addr,
   output logic [NRD-1:0][XLEN-1:0]  rd_data,
   output logic [NRD-1:0]            rd_busy,
   input  logic [NWR-1:0]            wr_en,
   input  logic [NWR-1:0][AW-1:0]    wr_addr,
   input  logic [NWR-1:0][XLEN-1:0]  wr_data,
   input  logic [NWR-1:0][AGE_W-1:0] wr_age,
   input  logic [NWR-1:0]            alloc_en,
   input  logic [NWR-1:0][AW-1:0]    alloc_addr,
   input  logic                      flush
);

   // reset also hides in-flight writes from the bypass
   logic [NWR-1:0] wen;
   assign wen = wr_en & {NWR{rst}};

   logic [NREGS-1:1][XLEN-1:0] mem;
   logic [NREGS-1:1][XLEN-1:0] wdat;
   logic [NREGS-1:1]           busy;
   logic [NREGS-1:1]           hit;
   logic [NREGS-1:1]           dup;

   for (genvar r = 1; r < NREGS; r++) begin : g_reg
      logic [NWR-1:0]  match;
      logic [NWR-1:0]  sel;
      logic [XLEN-1:0] wd;
      logic            al;
      logic [XLEN-1:0] q;
      logic            b;

      always_comb begin
         match = '0;
         al    = 1'b0;
         for (int j = 0; j < NWR; j++) begin
            match[j] = wen[j] && (wr_addr[j] == AW'(r));
            if (alloc_en[j] && alloc_addr[j] == AW'(r))
               al = 1'b1;
         end
      end

      rf_write_arbiter #(
         .NWR   (NWR),
         .AGE_W (AGE_W)
      ) u_arb (
         .match (match),
         .age   (wr_age),
         .hit   (hit[r]),
         .sel   (sel),
         .dup   (dup[r])
      );

      always_comb begin
         wd = '0;
         for (int j = 0; j < NWR; j++)
            if (sel[j])
               wd = wd | wr_data[j];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            q <= '0;
            b <= 1'b0;
         end else begin
            if (hit[r])
               q <= wd;
            if (flush)
               b <= 1'b0;
            else if (al)
               b <= 1'b1;
            else if (hit[r])
               b <= 1'b0;
         end
      end

      assign wdat[r] = wd;
      assign mem[r]  = q;
      assign busy[r] = b;
   end

   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_data[i] = '0;
         rd_busy[i] = 1'b0;
         if (rd_addr[i] != '0) begin
            rd_data[i] = hit[rd_addr[i]] ? wdat[rd_addr[i]]
                                         : mem[rd_addr[i]];
            rd_busy[i] = busy[rd_addr[i]] & ~hit[rd_addr[i]];
         end
      end
   end

   a_no_dup_age : assert property (
      @(posedge clk) disable iff (!rst) dup == '0
   );

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Directed self-checking bench for rf_mp_scoreboard.
// Inputs change 1ns after the rising edge; checks follow 1ns later.
module tb_rf_mp_scoreboard;

   logic                  clk;
   logic                  rst;
   logic [3:0][4:0]       rd_addr;
   logic [3:0][31:0]      rd_data;
   logic [3:0]            rd_busy;
   logic [1:0]            wr_en;
   logic [1:0][4:0]       wr_addr;
   logic [1:0][31:0]      wr_data;
   logic [1:0][7:0]       wr_age;
   logic [1:0]            alloc_en;
   logic [1:0][4:0]       alloc_addr;
   logic                  flush;

   int checks;
   int failures;

   rf_mp_scoreboard dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_age     (wr_age),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .flush      (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      wr_age     = '0;
      alloc_en   = '0;
      alloc_addr = '0;
      flush      = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic wr(input int p, input logic [4:0] a,
                     input logic [31:0] d, input logic [7:0] g);
      wr_en[p]   = 1'b1;
      wr_addr[p] = a;
      wr_data[p] = d;
      wr_age[p]  = g;
   endtask

   task automatic al(input int p, input logic [4:0] a);
      alloc_en[p]   = 1'b1;
      alloc_addr[p] = a;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      idle();
      rd_addr  = '{5'd4, 5'd3, 5'd7, 5'd5};
      #3;
      chk("rst_data0", rd_data[0], 32'h0);
      chk("rst_data3", rd_data[3], 32'h0);
      chk("rst_busy", {28'h0, rd_busy}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc();

      // age conflict on x7, newer port1 wins
      rd_addr[0] = 5'd7;
      wr(0, 5'd7, 32'h11, 8'd9);
      wr(1, 5'd7, 32'h22, 8'd10);
      #1;
      chk("conf_byp", rd_data[0], 32'h22);
      chk("conf_byp_busy", {31'h0, rd_busy[0]}, 32'h0);
      cyc();
      #1;
      chk("conf_store", rd_data[0], 32'h22);
      wr(0, 5'd7, 32'h11, 8'd10);
      wr(1, 5'd7, 32'h22, 8'd9);
      #1;
      chk("swap_byp", rd_data[0], 32'h11);
      cyc();
      #1;
      chk("swap_store", rd_data[0], 32'h11);

      // wrap: 0x02 is newer than 0xFE
      rd_addr[1] = 5'd3;
      wr(0, 5'd3, 32'hA, 8'hFE);
      wr(1, 5'd3, 32'hB, 8'h02);
      #1;
      chk("wrap_byp", rd_data[1], 32'hB);
      cyc();
      #1;
      chk("wrap_store", rd_data[1], 32'hB);

      // distinct addresses commit together
      rd_addr = '{5'd6, 5'd3, 5'd7, 5'd5};
      wr(0, 5'd5, 32'hDEAD, 8'd20);
      wr(1, 5'd6, 32'hBEEF, 8'd21);
      cyc();
      #1;
      chk("dist_x5", rd_data[0], 32'hDEAD);
      chk("dist_x6", rd_data[3], 32'hBEEF);

      // scoreboard on x4
      rd_addr[2] = 5'd4;
      al(0, 5'd4);
      #1;
      chk("sb_c0", {31'h0, rd_busy[2]}, 32'h0);
      cyc();
      #1;
      chk("sb_c1", {31'h0, rd_busy[2]}, 32'h1);
      cyc();
      cyc();
      wr(1, 5'd4, 32'h55, 8'd30);
      #1;
      chk("sb_c3_busy", {31'h0, rd_busy[2]}, 32'h0);
      chk("sb_c3_data", rd_data[2], 32'h55);
      cyc();
      #1;
      chk("sb_c4_busy", {31'h0, rd_busy[2]}, 32'h0);
      chk("sb_c4_data", rd_data[2], 32'h55);
      al(0, 5'd4);
      wr(1, 5'd4, 32'h66, 8'd31);
      cyc();
      #1;
      chk("sb_aw_busy", {31'h0, rd_busy[2]}, 32'h1);
      chk("sb_aw_data", rd_data[2], 32'h66);

      // flush clears busy, including same-cycle alloc
      rd_addr = '{5'd6, 5'd9, 5'd2, 5'd1};
      al(0, 5'd1);
      al(1, 5'd2);
      cyc();
      al(0, 5'd9);
      al(1, 5'd9);
      cyc();
      #1;
      chk("fl_pre", {28'h0, rd_busy}, 32'h7);
      flush = 1'b1;
      al(0, 5'd6);
      cyc();
      #1;
      chk("fl_post", {28'h0, rd_busy}, 32'h0);
      rd_addr = '{5'd6, 5'd4, 5'd7, 5'd5};
      #1;
      chk("fl_busy_x4", {31'h0, rd_busy[2]}, 32'h0);
      chk("fl_data_x5", rd_data[0], 32'hDEAD);
      chk("fl_data_x4", rd_data[2], 32'h66);

      // x0 ignores writes and allocs
      rd_addr[1] = 5'd0;
      wr(0, 5'd0, 32'hFFFF, 8'd40);
      wr(1, 5'd0, 32'hFFFF, 8'd40);
      al(0, 5'd0);
      al(1, 5'd0);
      #1;
      chk("x0_byp", rd_data[1], 32'h0);
      chk("x0_byp_busy", {31'h0, rd_busy[1]}, 32'h0);
      cyc();
      #1;
      chk("x0_data", rd_data[1], 32'h0);
      chk("x0_busy", {31'h0, rd_busy[1]}, 32'h0);

      // async reset mid-cycle with a write in flight
      al(0, 5'd7);
      cyc();
      rd_addr = '{5'd8, 5'd3, 5'd7, 5'd5};
      #1;
      chk("pre_rst_busy", {31'h0, rd_busy[1]}, 32'h1);
      wr(0, 5'd8, 32'h1234, 8'd50);
      al(1, 5'd3);
      #1;
      chk("pre_rst_byp", rd_data[3], 32'h1234);
      rst = 1'b0;
      #1;
      chk("rst_x5", rd_data[0], 32'h0);
      chk("rst_x8", rd_data[3], 32'h0);
      chk("rst_busy_all", {28'h0, rd_busy}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      #1;
      chk("post_rst_x8", rd_data[3], 32'h0);
      chk("post_rst_x3b", {31'h0, rd_busy[2]}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
